// File: rtl/lu_icode_sequencer.sv
// On-chip instruction source for the LU processor: a 16x8 program store fetched
// sequentially from a start address and delivered over valid/ready until HALT.
module lu_icode_sequencer #(
  parameter int              AW        = 4,
  parameter int              IW        = 8,
  parameter logic [IW-1:0]   HALT_CODE = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_wdata,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic [IW-1:0] icode,
  output logic          icode_valid,
  input  logic          icode_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] mem [0:(1<<AW)-1];
  logic [IW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          inflight;
  logic [IW-1:0] buf0, buf1;
  logic [1:0]    count;
  logic [2:0]    occ;
  logic          pop, push, issue, halt_ret, restart;

  assign icode       = buf0;
  assign icode_valid = (count != 2'd0);
  assign pop         = icode_valid & icode_ready;
  assign restart     = start && (state != S_RUN);
  assign halt_ret    = (state == S_RUN) && inflight && (rd_data == HALT_CODE);
  assign push        = (state == S_RUN) && inflight && !halt_ret;
  // Occupancy counts the read still in flight so the buffer can never overflow.
  assign occ         = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == S_RUN) && !halt_ret && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start)    state_nx = S_RUN;
      S_RUN:   if (halt_ret) state_nx = S_HALT;
      S_HALT:  if (start)    state_nx = S_RUN;
      default:               state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_RUN) || ((state == S_HALT) && (count != 2'd0));
    halted = (state == S_HALT) && (count == 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      pc       <= '0;
    end else if (restart) begin
      inflight <= 1'b0;
      pc       <= start_addr;
    end else if (state == S_RUN) begin
      inflight <= issue;
      if (halt_ret)   pc <= rd_addr;
      else if (issue) pc <= pc + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // Head register is cleared on reset/flush so icode reads 0 until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      buf0  <= '0;
    end else if (restart) begin
      count <= 2'd0;
      buf0  <= '0;
    end else if (push && pop) begin
      if (count == 2'd1) buf0 <= rd_data;
      else               buf0 <= buf1;
    end else if (push) begin
      if (count == 2'd0) buf0 <= rd_data;
      count <= count + 2'd1;
    end else if (pop) begin
      if (count == 2'd2) buf0 <= buf1;
      count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!restart && push && ((pop && count == 2'd2) || (!pop && count == 2'd1)))
      buf1 <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (prog_we && state != S_RUN) mem[prog_addr] <= prog_wdata;
    if (issue) begin
      rd_data <= mem[pc];
      rd_addr <= pc;
    end
  end

endmodule

// File: doc/lu_icode_sequencer.md
# lu_icode_sequencer

Hardware instruction source for the LU processor: holds a 16-entry × 8-bit program store, fetches instruction codes sequentially from a start address, and delivers them to the processor's ICODE input over a valid/ready handshake. It replaces stimulus-file driving of ICODE with an on-chip fetch path. A 2-entry output buffer absorbs the one-cycle memory read latency under backpressure. Fetch stops on a HALT opcode.

## Interface
- `AW`, 4, program address width (depth = 2^AW = 16)
- `IW`, 8, instruction code width
- `HALT_CODE`, 8'hFF, opcode that terminates fetch; never delivered

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `prog_we`  in  1  program store write strobe
- `prog_addr`  in  AW  program store write address
- `prog_wdata`  in  IW  program store write data
- `start`  in  1  one-cycle pulse: begin fetch at `start_addr`
- `start_addr`  in  AW  first fetch address
- `icode`  out  IW  instruction code to the processor (buffer head)
- `icode_valid`  out  1  `icode` holds a valid code
- `icode_ready`  in  1  processor accepts `icode` this cycle
- `pc`  out  AW  next fetch address; the HALT address once halted
- `busy`  out  1  state is RUN, or HALT with the buffer not yet drained
- `halted`  out  1  HALT state and buffer empty

## Operation
- Reset (`rst`=0): state IDLE, buffer empty, in-flight flag 0. Outputs: `icode`=0, `icode_valid`=0, `pc`=0, `busy`=0, `halted`=0. Program store is not reset.
- States: IDLE, RUN, HALT.
  - IDLE --start--> RUN
  - RUN --HALT_CODE returned--> HALT
  - HALT --start--> RUN
- Program writes: `prog_we` is honoured only in IDLE or HALT, and is ignored in RUN. The write lands at the rising edge.
- `start` in IDLE or HALT:
  - `pc` <= `start_addr`
  - buffer flushed
  - in-flight flag cleared
  - `halted` <= 0
- `start` in RUN is ignored.
- Fetch issue (RUN only):
  - Issue condition: `count + inflight - pop < 2`, where `pop` = `icode_valid & icode_ready`.
  - Issue reads mem[`pc`] into a read register and latches the address.
  - Issue sets the in-flight flag and does `pc` <= `pc`+1, wrapping 15 → 0.
- Return (cycle after issue):
  - Data ≠ `HALT_CODE`: pushed into the buffer.
  - Data = `HALT_CODE`: not pushed; state → HALT; `pc` <= latched HALT address; any read issued in the same cycle is discarded (in-flight cleared, no push); no further issues.
- Buffer: 2-entry FIFO, `count` 0..2.
  - `icode_valid` = (`count` ≠ 0); `icode` = head entry.
  - `icode` keeps its last value when empty. It is 0 after reset or flush.
  - Push and pop in the same cycle keep `count` unchanged.
  - Overflow cannot occur by construction; verification asserts `count` ≤ 2.
- HALT: entries already buffered are still delivered under normal handshake. `halted` rises on the edge where the last entry pops, or immediately if the buffer is empty at HALT entry.
- `icode`/`icode_valid` are stable while `icode_valid`=1 and `icode_ready`=0.
- Asynchronous reset mid-RUN aborts everything immediately. Outputs return to reset values with no partial delivery.

## Timing
- `start` sampled at edge E0 → first read issued at E1 → first `icode_valid`=1 after E2 (2-cycle start latency).
- Steady state with `icode_ready` held at 1: one code per cycle, no bubbles.
- `icode_ready`=0: at most 2 codes are buffered and fetch stalls. When ready returns, the first pop occurs that cycle and issue resumes the same cycle.
- HALT detection: `HALT_CODE` at address A is issued at edge En and returns at En+1. At En+1, state becomes HALT and `pc`=A. `halted` follows once the buffer drains.
- Program write at edge Ew is readable by a fetch issued at Ew+1 or later.

## Test plan
- Load mem[0..3] = 11,22,33,FF. Pulse `start` with `start_addr`=0 and hold ready=1. Expected: `icode` 11,22,33 on consecutive cycles; `halted`=1 and `pc`=3 afterwards; 5 is never delivered, even if mem[4]=5.
- Same program, but `icode_ready`=0 for 6 cycles after the first valid. Expected: `icode` holds 11 stably, `count` saturates at 2, and the sequence 11,22,33 is delivered intact when ready rises.
- Load mem[14]=AA, mem[15]=BB, mem[0]=CC, mem[1]=FF. Start at 14. Expected: AA,BB,CC delivered (wrap 15 → 0), `pc`=1 at halt.
- Assert `prog_we` with addr 2, data 44 during RUN. Expected: mem[2] unchanged. Repeat in HALT, then start at 2. Expected: 44 delivered.
- Drive `rst`=0 mid-RUN with 2 entries buffered. Expected: `icode_valid`=0, `icode`=0, `pc`=0, `busy`=0 immediately, with no further codes until a new `start`.
- Pulse `start` during RUN. Expected: ignored, sequence continues. Pulse `start` during HALT with 1 entry still buffered. Expected: the buffer is flushed (entry dropped) and fetch restarts at the new `start_addr`.
